// File: rtl/mole_pkg.sv
// Shared types and constants for the mole spawner: hole count, FSM states, difficulty encodings.
package mole_pkg;

  localparam int unsigned NumHolesDefault = 9;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StDone,
    StWaitLow
  } state_e;

  localparam logic [2:0] DiffEasy   = 3'b001;
  localparam logic [2:0] DiffMedium = 3'b010;
  localparam logic [2:0] DiffHard   = 3'b100;

  // Anything that is not a clean one-hot selection falls back to the medium target.
  function automatic logic [1:0] diff_to_target(input logic [2:0] diff);
    case (diff)
      DiffEasy:   return 2'd1;
      DiffMedium: return 2'd2;
      DiffHard:   return 2'd3;
      default:    return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 11-bit Fibonacci LFSR, polynomial x^11 + x^9 + 1; a zero seed is replaced by 1.
module mole_lfsr #(
  parameter logic [10:0] SEED = 11'h5A5
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] value
);

  localparam logic [10:0] Init = (SEED == 11'd0) ? 11'd1 : SEED;

  logic [10:0] value_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= Init;
    end else begin
      value_q <= {value_q[9:0], value_q[10] ^ value_q[8]};
    end
  end

  assign value = value_q;

endmodule

// File: rtl/mole_spawner.sv
// Picks 1-3 free holes per spawn request using the LFSR, one candidate per cycle.
// Define SPAWN_STATS_EN to enable the saturating spawn_count statistic.
module mole_spawner
  import mole_pkg::*;
#(
  parameter int unsigned NUM_HOLES = NumHolesDefault,
  parameter logic [10:0] LFSR_SEED = 11'h5A5,
  parameter int unsigned MAX_TRIES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spawn_req,
  input  logic [2:0]           difficulty_switches,
  input  logic [NUM_HOLES-1:0] occupied,
  output logic [10:0]          random_value,
  output logic [NUM_HOLES-1:0] mole_mask,
  output logic                 spawn_valid,
  output logic                 spawn_partial,
  output logic [15:0]          spawn_count
);

  localparam int unsigned TryW = $clog2(MAX_TRIES + 1);

  state_e               state_q;
  logic [1:0]           target_q;
  logic [1:0]           acc_q;
  logic [TryW-1:0]      tries_q;
  logic [NUM_HOLES-1:0] work_q;
  logic [NUM_HOLES-1:0] occ_q;

  int unsigned          free_cnt;
  logic [1:0]           target_d;
  logic [NUM_HOLES-1:0] cand_oh;
  logic [NUM_HOLES-1:0] work_nx;
  logic                 accept;
  logic                 last_hit;
  logic                 tries_out;

  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (random_value)
  );

  // Target is clamped to the number of free holes so a full board completes immediately.
  always_comb begin
    free_cnt = 0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      if (!occupied[i]) free_cnt = free_cnt + 1;
    end
    target_d = diff_to_target(difficulty_switches);
    if (32'(target_d) > free_cnt) target_d = 2'(free_cnt);
  end

  always_comb begin
    cand_oh   = {{(NUM_HOLES-1){1'b0}}, 1'b1} << random_value[3:0];
    accept    = (32'(random_value[3:0]) < NUM_HOLES) && ((cand_oh & (work_q | occ_q)) == '0);
    work_nx   = work_q | cand_oh;
    last_hit  = (acc_q + 2'd1) == target_q;
    tries_out = (32'(tries_q) + 32'd1) >= MAX_TRIES;
  end

  // Results are registered on the edge entering StDone, so spawn_valid is high during StDone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      target_q      <= '0;
      acc_q         <= '0;
      tries_q       <= '0;
      work_q        <= '0;
      occ_q         <= '0;
      mole_mask     <= '0;
      spawn_valid   <= 1'b0;
      spawn_partial <= 1'b0;
    end else begin
      spawn_valid   <= 1'b0;
      spawn_partial <= 1'b0;
      case (state_q)
        StIdle: begin
          if (spawn_req) begin
            target_q <= target_d;
            occ_q    <= occupied;
            work_q   <= '0;
            acc_q    <= '0;
            tries_q  <= '0;
            if (target_d == 2'd0) begin
              mole_mask   <= '0;
              spawn_valid <= 1'b1;
              state_q     <= StDone;
            end else begin
              state_q <= StDraw;
            end
          end
        end
        StDraw: begin
          if (!spawn_req) begin
            state_q <= StIdle;
          end else if (accept) begin
            work_q <= work_nx;
            acc_q  <= acc_q + 2'd1;
            if (last_hit) begin
              mole_mask   <= work_nx;
              spawn_valid <= 1'b1;
              state_q     <= StDone;
            end
          end else begin
            tries_q <= tries_q + 1'b1;
            if (tries_out) begin
              mole_mask     <= work_q;
              spawn_valid   <= 1'b1;
              spawn_partial <= 1'b1;
              state_q       <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StWaitLow;
        end
        StWaitLow: begin
          if (!spawn_req) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef SPAWN_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (state_q == StDone && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign spawn_count = count_q;
`else
  assign spawn_count = '0;
`endif

endmodule

// File: tb/tb_mole_spawner.sv
// Randomized bench for mole_spawner against a transaction-level model of spawn outcomes.
module tb_mole_spawner;

  localparam int unsigned   NH       = 9;
  localparam int unsigned   MaxTries = 32;
  localparam logic [10:0]   Seed     = 11'h5A5;

  logic          clk;
  logic          reset;
  logic          spawn_req;
  logic [2:0]    difficulty_switches;
  logic [NH-1:0] occupied;
  logic [10:0]   random_value;
  logic [NH-1:0] mole_mask;
  logic          spawn_valid;
  logic          spawn_partial;
  logic [15:0]   spawn_count;

  mole_spawner dut (
    .clk                 (clk),
    .reset               (reset),
    .spawn_req           (spawn_req),
    .difficulty_switches (difficulty_switches),
    .occupied            (occupied),
    .random_value        (random_value),
    .mole_mask           (mole_mask),
    .spawn_valid         (spawn_valid),
    .spawn_partial       (spawn_partial),
    .spawn_count         (spawn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_total = 0;
  int unsigned   n_bad   = 0;
  logic [10:0]   lfsr_m;
  logic [NH-1:0] mask_m;
  int unsigned   spawns_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Next LFSR state from the polynomial x^11 + x^9 + 1, in integer arithmetic.
  function automatic logic [10:0] lfsr_step(input logic [10:0] s);
    int unsigned v;
    int unsigned fb;
    v  = s;
    fb = ((v >> 10) ^ (v >> 8)) & 1;
    return 11'(((v << 1) | fb) & 32'h7FF);
  endfunction

  function automatic int unsigned want_target(input logic [2:0] d, input logic [NH-1:0] occ);
    int unsigned base;
    int unsigned free;
    if (d == 3'd1)      base = 1;
    else if (d == 3'd2) base = 2;
    else if (d == 3'd4) base = 3;
    else                base = 2;
    free = NH - $countones(occ);
    return (base < free) ? base : free;
  endfunction

  function automatic int unsigned exp_count();
`ifdef SPAWN_STATS_EN
    return (spawns_m > 65535) ? 65535 : spawns_m;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    lfsr_m = lfsr_step(lfsr_m);
    #1;
    check("random_value", 32'(random_value), 32'(lfsr_m));
  endtask

  task automatic do_spawn(input logic [2:0] d, input logic [NH-1:0] occ, input int unsigned hold);
    int unsigned   tgt;
    int unsigned   acc;
    int unsigned   tries;
    int unsigned   n;
    int unsigned   lat;
    int unsigned   pulses;
    int unsigned   idx;
    logic [10:0]   s;
    logic [NH-1:0] m;
    bit            got;
    difficulty_switches = d;
    occupied            = occ;
    spawn_req           = 1'b1;
    tgt   = want_target(d, occ);
    s     = lfsr_m;
    m     = '0;
    acc   = 0;
    tries = 0;
    n     = 0;
    while (acc < tgt && tries < MaxTries) begin
      s   = lfsr_step(s);
      n++;
      idx = s % 16;
      if (idx < NH && !m[idx] && !occ[idx]) begin
        m[idx] = 1'b1;
        acc++;
      end else begin
        tries++;
      end
    end
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= int'(n) + 5 && !got; c++) begin
      tick();
      if (spawn_valid === 1'b1) begin
        got = 1'b1;
        lat = c;
      end
    end
    check("latency", lat, n + 1);
    if (got) begin
      spawns_m++;
      mask_m = m;
      check("mole_mask", 32'(mole_mask), 32'(m));
      check("spawn_partial", 32'(spawn_partial), (acc < tgt) ? 1 : 0);
      check("mask_vs_occupied", 32'(mole_mask & occ), 0);
    end
    tick();
    check("valid_one_cycle", 32'(spawn_valid), 0);
    check("spawn_count", 32'(spawn_count), exp_count());
    pulses = 0;
    repeat (hold) begin
      tick();
      if (spawn_valid) pulses++;
    end
    check("no_second_pulse", pulses, 0);
    spawn_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int unsigned   pulses;
    int unsigned   mode;
    logic [NH-1:0] occ;
    reset               = 1'b1;
    spawn_req           = 1'b0;
    difficulty_switches = 3'b000;
    occupied            = '0;
    mask_m              = '0;
    spawns_m            = 0;
    #3;
    check("reset_mask", 32'(mole_mask), 0);
    check("reset_valid", 32'(spawn_valid), 0);
    check("reset_partial", 32'(spawn_partial), 0);
    check("reset_count", 32'(spawn_count), 0);
    check("reset_random", 32'(random_value), 32'(Seed));
    #5;
    reset  = 1'b0;
    lfsr_m = Seed;

    // Easy, empty board, request held long: exactly one mole and one pulse.
    do_spawn(3'b001, '0, 20);
    check("easy_popcount", $countones(mole_mask), 1);

    // Hard with only holes 0..2 free.
    do_spawn(3'b100, 9'h1F8, 2);
    check("hard_in_free_holes", 32'(mole_mask & ~9'h007), 0);

    // Full board: immediate empty spawn.
    do_spawn(3'b010, 9'h1FF, 2);
    check("full_board_mask", 32'(mole_mask), 0);

    // Abort on the second draw cycle.
    do_spawn(3'b100, '0, 0);
    difficulty_switches = 3'b100;
    occupied            = '0;
    spawn_req           = 1'b1;
    tick();
    tick();
    spawn_req = 1'b0;
    pulses    = 0;
    repeat (6) begin
      tick();
      if (spawn_valid) pulses++;
    end
    check("abort_no_valid", pulses, 0);
    check("abort_mask_held", 32'(mole_mask), 32'(mask_m));
    do_spawn(3'b100, '0, 1);

    // Asynchronous reset in the middle of a draw.
    difficulty_switches = 3'b100;
    occupied            = '0;
    spawn_req           = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("midreset_mask", 32'(mole_mask), 0);
    check("midreset_valid", 32'(spawn_valid), 0);
    check("midreset_partial", 32'(spawn_partial), 0);
    check("midreset_count", 32'(spawn_count), 0);
    spawn_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("release_random", 32'(random_value), 32'(Seed));
    lfsr_m   = Seed;
    mask_m   = '0;
    spawns_m = 0;
    pulses   = 0;
    repeat (5) begin
      tick();
      if (spawn_valid) pulses++;
    end
    check("no_valid_after_reset", pulses, 0);

    // Three spawns after reset for the statistics counter.
    do_spawn(3'b001, 9'h011, 0);
    do_spawn(3'b010, 9'h100, 0);
    do_spawn(3'b100, 9'h0F0, 0);
    check("count_after_three", 32'(spawn_count), exp_count());

    // Randomized spawns, including illegal difficulty codes and crowded boards.
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0:       occ = '0;
        1:       occ = NH'($urandom);
        2:       occ = ~(NH'(1) << $urandom_range(0, NH - 1));
        default: occ = NH'($urandom) & NH'($urandom);
      endcase
      do_spawn(3'($urandom_range(0, 7)), occ, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
